l2_line_responder: RTL and testbench
====================================

Name: l2_line_responder

Overview:
- Next-level (L2) side of the line-request interface driven by the L1 instruction cache.
- Accepts 26-bit line-address commands (READ, INVALIDATE) and looks them up in a direct-mapped L2 tag store.
- Answers a hit locally. On a miss it fetches the line from main memory through a req/ack port, fills the tag store, then answers.
- Keeps hit, miss and read counters for the statistics module.

Parameters:
- INDEX_BITS, 10, L2 index width; the store has 2**INDEX_BITS lines.
- TAG_BITS, 16, L2 tag width; must equal 26-INDEX_BITS.
- HIT_LAT, 1, extra LOOKUP cycles on a hit (1..7).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_in  in  2  command from L1: 00 idle, 01 READ, 10 INVALIDATE, 11 reserved (ignored).
- add_in  in  26  line address from L1 (addr[31:6]).
- busy  out  1  high while a command is in flight; L1 must hold cmd_in=00 while busy.
- resp_valid  out  1  one-cycle pulse when READ data is ready.
- resp_add  out  26  line address being answered; valid only with resp_valid.
- mem_req  out  1  main-memory fetch request, level-held until mem_ack.
- mem_add  out  26  line address to memory.
- mem_ack  in  1  one-cycle memory completion pulse.
- hit  out  32  READ hits since reset.
- miss  out  32  READ misses since reset.
- reads  out  32  READ commands accepted since reset.

Behaviour:
- Index is add_in[INDEX_BITS-1:0]; tag is add_in[25:INDEX_BITS].
- Storage is a valid vector plus a tag array. Only the valid vector is reset.
- Reset (rst_n=0, async):
  - state=IDLE; all valid bits=0.
  - busy=0, resp_valid=0, mem_req=0.
  - resp_add=0, mem_add=0.
  - hit=miss=reads=0.
  - Takes effect immediately, including mid-fetch: mem_req drops and the pending fill is discarded.
  - A mem_ack arriving after reset is ignored.
- FSM states: IDLE, LOOKUP, FETCH, FILL, RESPOND.
- IDLE, cmd_in=01:
  - latch add_in; reads+=1; busy=1.
  - load delay counter with HIT_LAT; go to LOOKUP.
- IDLE, cmd_in=10:
  - single cycle; clear valid[index] only if valid and tag matches.
  - no counter change; busy stays 0; remain in IDLE.
- IDLE, cmd_in=00 or 11: no action.
- LOOKUP: decrement the delay counter each cycle. When it reaches 0:
  - hit (valid and tag match): hit+=1; go to RESPOND.
  - miss: miss+=1; mem_req=1; mem_add=latched address; go to FETCH.
- Hit latency: command sampled at edge N gives resp_valid high in the cycle after edge N+HIT_LAT+1.
- FETCH: hold mem_req and mem_add stable until mem_ack is sampled high. Then mem_req=0 and go to FILL. No timeout.
- FILL (one cycle): tag[index]=latched tag; valid[index]=1. The line at that index is overwritten unconditionally; there is no writeback (instruction lines are clean). Go to RESPOND.
- RESPOND (one cycle): resp_valid=1; resp_add=latched address. Go to IDLE; busy=0 on the same edge.
- The earliest next command is sampled on the edge after resp_valid.
- Commands presented while busy=1 are ignored and not counted (protocol violation; the bench flags it).
- A READ never hits on a line invalidated earlier; the invalidate is completed in IDLE before any later READ.
- Counters are 32-bit and wrap modulo 2**32.
- At every RESPOND, hit+miss equals reads.
- mem_ack outside FETCH is ignored.

Test Plan:
- Reset, then READ 0x0000040 with mem_ack 3 cycles after mem_req → mem_req high with mem_add=0x0000040; fill; resp_valid with resp_add=0x0000040; miss=1, hit=0, reads=1.
- Repeat READ 0x0000040 → no mem_req; resp_valid 2 cycles after the command edge (HIT_LAT=1); hit=1, reads=2.
- READ 0x0000440 (same index 0x040, tag 0x0001) after 0x0000040 → miss and refill. Then READ 0x0000040 → miss again (conflict eviction); miss=3.
- INVALIDATE 0x0000440 → next READ 0x0000440 misses. INVALIDATE 0x0000999 on a non-resident line → no state change, counters unchanged.
- Assert rst_n=0 for 1 cycle while in FETCH; send a late mem_ack → mem_req=0 and busy=0 immediately; all counters 0; late mem_ack ignored; next READ of the same address misses.
- Drive cmd_in=01 continuously while busy → exactly one read counted per transaction; reads increments only on IDLE acceptances.

Source files
------------

// File: rtl/l2_line_responder.sv
// L2 side of the L1 line-request interface: direct-mapped tag lookup,
// main-memory fetch on miss, and hit/miss/read statistics counters.
module l2_line_responder #(
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 16,
  parameter int HIT_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cmd_in,
  input  logic [25:0] add_in,
  output logic        busy,
  output logic        resp_valid,
  output logic [25:0] resp_add,
  output logic        mem_req,
  output logic [25:0] mem_add,
  input  logic        mem_ack,
  output logic [31:0] hit,
  output logic [31:0] miss,
  output logic [31:0] reads
);
  // state   | meaning
  // IDLE    | waiting for a command; invalidates complete here in one cycle
  // LOOKUP  | counting down the hit latency, then tag compare
  // FETCH   | mem_req held until mem_ack
  // FILL    | write tag and set valid for the fetched line
  // RESPOND | one-cycle resp_valid pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FETCH, S_FILL, S_RESPOND
  } state_t;

  localparam int LINES = 1 << INDEX_BITS;

  state_t                state_q, state_d;
  logic [25:0]           addr_q;
  logic [2:0]            dly_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem [LINES];

  logic [INDEX_BITS-1:0] in_idx, q_idx;
  logic [TAG_BITS-1:0]   in_tag, q_tag;
  logic                  lookup_hit, inv_match;
  logic                  accept_rd, do_inv, decide;

  assign in_idx = add_in[INDEX_BITS-1:0];
  assign in_tag = add_in[25:INDEX_BITS];
  assign q_idx  = addr_q[INDEX_BITS-1:0];
  assign q_tag  = addr_q[25:INDEX_BITS];

  assign lookup_hit = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);
  assign inv_match  = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);

  // The latched address only changes on acceptance, so it doubles as the
  // stable memory address and the response address.
  assign resp_add = addr_q;
  assign mem_add  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    accept_rd  = 1'b0;
    do_inv     = 1'b0;
    decide     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_in == 2'b01) begin
          accept_rd = 1'b1;
          state_d   = S_LOOKUP;
        end else if (cmd_in == 2'b10) begin
          do_inv = inv_match;
        end
      end
      S_LOOKUP: begin
        if (dly_q == 3'd0) begin
          decide  = 1'b1;
          state_d = lookup_hit ? S_RESPOND : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL:    state_d = S_RESPOND;
      S_RESPOND: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      dly_q   <= '0;
      valid_q <= '0;
      hit     <= '0;
      miss    <= '0;
      reads   <= '0;
    end else begin
      if (accept_rd) begin
        addr_q <= add_in;
        dly_q  <= 3'(HIT_LAT);
        reads  <= reads + 32'd1;
      end else if (state_q == S_LOOKUP && dly_q != 3'd0) begin
        dly_q <= dly_q - 3'd1;
      end
      if (decide) begin
        if (lookup_hit) hit  <= hit + 32'd1;
        else            miss <= miss + 32'd1;
      end
      if (do_inv)             valid_q[in_idx] <= 1'b0;
      if (state_q == S_FILL)  valid_q[q_idx]  <= 1'b1;
    end
  end

  // Tag contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL) tag_mem[q_idx] <= q_tag;
  end

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: transaction-level cache model predicting
// every output cycle by cycle, directed scenarios then random traffic.
module tb_l2_line_responder;
  localparam int HIT_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd_in;
  logic [25:0] add_in;
  logic        busy, resp_valid, mem_req, mem_ack;
  logic [25:0] resp_add, mem_add;
  logic [31:0] hit, miss, reads;

  l2_line_responder #(.INDEX_BITS(10), .TAG_BITS(16), .HIT_LAT(HIT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .add_in(add_in),
    .busy(busy), .resp_valid(resp_valid), .resp_add(resp_add),
    .mem_req(mem_req), .mem_add(mem_add), .mem_ack(mem_ack),
    .hit(hit), .miss(miss), .reads(reads)
  );

  always #5 clk = ~clk;

  // model: resident lines and expected outputs after the next edge
  bit          m_valid [1024];
  logic [15:0] m_tag   [1024];
  bit          exp_busy, exp_rv, exp_mr;
  logic [25:0] exp_resp_add, exp_mem_add;
  logic [31:0] exp_hit, exp_miss, exp_reads;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("mem_req", 32'(mem_req), 32'(exp_mr));
      chk("hit_cnt", hit, exp_hit);
      chk("miss_cnt", miss, exp_miss);
      chk("reads_cnt", reads, exp_reads);
      if (exp_rv) chk("resp_add", 32'(resp_add), 32'(exp_resp_add));
      if (exp_mr) chk("mem_add", 32'(mem_add), 32'(exp_mem_add));
    end
  end

  task automatic step(input logic [1:0] c, input logic [25:0] a, input logic ack);
    @(negedge clk);
    cmd_in  = c;
    add_in  = a;
    mem_ack = ack;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) m_valid[i] = 0;
    exp_busy = 0; exp_rv = 0; exp_mr = 0;
    exp_hit = 0; exp_miss = 0; exp_reads = 0;
  endtask

  // Drives one READ; hold keeps cmd_in=01 (with junk addresses) while busy.
  task automatic do_read(input logic [25:0] a, input int ack_dly, input bit hold);
    int   idx;
    bit   is_hit;
    logic [1:0] bc;
    idx    = int'(a[9:0]);
    is_hit = m_valid[idx] && (m_tag[idx] == a[25:10]);
    bc     = hold ? 2'b01 : 2'b00;
    step(2'b01, a, 1'b0);
    exp_busy = 1; exp_reads++;
    for (int i = 0; i < HIT_LAT; i++) step(bc, 26'($urandom), 1'b0);
    step(bc, 26'($urandom), 1'b0);
    if (is_hit) begin
      exp_rv = 1; exp_resp_add = a; exp_hit++;
    end else begin
      exp_mr = 1; exp_mem_add = a; exp_miss++;
      for (int i = 0; i < ack_dly; i++) step(bc, 26'($urandom), 1'b0);
      step(bc, 26'($urandom), 1'b1);
      exp_mr = 0;
      m_valid[idx] = 1; m_tag[idx] = a[25:10];
      step(bc, 26'($urandom), 1'b0);
      exp_rv = 1; exp_resp_add = a;
    end
    step(bc, 26'($urandom), 1'b0);
    exp_rv = 0; exp_busy = 0;
  endtask

  task automatic do_inv(input logic [25:0] a);
    int idx;
    idx = int'(a[9:0]);
    step(2'b10, a, 1'b0);
    if (m_valid[idx] && m_tag[idx] == a[25:10]) m_valid[idx] = 0;
  endtask

  task automatic settle();
    step(2'b00, 26'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [25:0] ra;
    int          sel;
    rst_n = 0; cmd_in = 0; add_in = 0; mem_ack = 0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_resp_add", 32'(resp_add), 32'd0);
    chk("rst_mem_add", 32'(mem_add), 32'd0);
    chk("rst_reads", reads, 32'd0);
    rst_n = 1;

    // miss, hit, conflict evictions
    do_read(26'h0000040, 3, 0);
    settle();
    chk("lit_miss1", miss, 32'd1);
    chk("lit_hit0", hit, 32'd0);
    chk("lit_reads1", reads, 32'd1);
    do_read(26'h0000040, 0, 0);
    settle();
    chk("lit_hit1", hit, 32'd1);
    chk("lit_reads2", reads, 32'd2);
    do_read(26'h0000440, 1, 0);
    do_read(26'h0000040, 2, 0);
    settle();
    chk("lit_miss3", miss, 32'd3);
    chk("lit_reads4", reads, 32'd4);

    // invalidates: resident, wrong tag, non-resident
    do_read(26'h0000440, 0, 0);
    do_inv(26'h0000440);
    do_read(26'h0000440, 1, 0);
    do_inv(26'h0000840);
    do_inv(26'h0000999);
    do_read(26'h0000440, 0, 0);
    settle();
    chk("lit_miss5", miss, 32'd5);
    chk("lit_hit2", hit, 32'd2);
    chk("lit_reads7", reads, 32'd7);

    // reset in the middle of a fetch, then a late ack
    step(2'b01, 26'h0000040, 1'b0);
    exp_busy = 1; exp_reads++;
    for (int i = 0; i < HIT_LAT; i++) step(2'b00, 26'd0, 1'b0);
    step(2'b00, 26'd0, 1'b0);
    exp_mr = 1; exp_mem_add = 26'h0000040; exp_miss++;
    step(2'b00, 26'd0, 1'b0);
    @(negedge clk);
    rst_n = 0;
    clear_model();
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_reads", reads, 32'd0);
    chk("async_miss", miss, 32'd0);
    step(2'b00, 26'd0, 1'b1);
    rst_n = 1;
    step(2'b00, 26'd0, 1'b0);
    do_read(26'h0000040, 2, 0);
    settle();
    chk("lit_rst_miss", miss, 32'd1);
    chk("lit_rst_reads", reads, 32'd1);

    // READ held high throughout the transaction
    do_read(26'h0000040, 0, 1);
    do_read(26'h0000123, 2, 1);
    settle();
    chk("lit_hold_reads", reads, 32'd3);
    chk("lit_hold_hit", hit, 32'd1);

    // random traffic over a few conflicting indices
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 2));
      ra  = {16'($urandom_range(0, 2)), (sel == 0) ? 10'h040 : (sel == 1) ? 10'h041 : 10'h199};
      case ($urandom_range(0, 5))
        0, 1, 2: do_read(ra, int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
        3:       do_inv(ra);
        4:       step(2'b11, ra, 1'b0);
        default: step(2'b00, ra, bit'($urandom_range(0, 1)));
      endcase
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
